enemy_hit_detector: RTL and testbench

- Producer side of the enemy collision interface: generates the collision pulse and one-hot HitEdgeCode that the enemy motion FSM consumes during its move phase.
- Watches the raster scan and counts wall pixels that fall inside four edge strips of the enemy's 32x32 box.
- Resolves one dominant edge per frame and reports it once, before the next startOfFrame.
- Sits between the wall/maze drawing logic and one enemy instance; one detector per enemy.

---
 rtl/enemy_hit_detector.sv | 255 +++++++++++++++++++++++++
 tb/tb_enemy_hit_detector.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_hit_detector.sv
// -----------------------------------------------------------------------------
// enemy_hit_detector
//
// Watches the raster scan and counts wall pixels that land inside four edge
// strips (TOP, BOTTOM, LEFT, RIGHT) of one enemy's bounding box. Once the scan
// has passed the bottom of the box, the dominant strip is resolved. If it
// holds enough hits, it is reported once per frame as a one-cycle collision
// pulse together with a held one-hot HitEdgeCode.
//
// Ports:
//   clk                 system clock
//   resetN              asynchronous active-low reset
//   startOfFrame        one-cycle pulse at the start of each frame
//   game_on             detection enabled while high
//   pixelX / pixelY     current raster position (11 bit, unsigned)
//   wallDrawingRequest  wall/brick pixel present at the raster position
//   enemyTopLeftX/Y     enemy box top-left corner (11 bit, signed)
//   collision           one-cycle pulse when an edge hit is resolved
//   HitEdgeCode         one-hot edge: LEFT=1000 TOP=0100 RIGHT=0010 BOTTOM=0001
// -----------------------------------------------------------------------------
module enemy_hit_detector #(
  parameter int OBJECT_W    = 32,
  parameter int OBJECT_H    = 32,
  parameter int MARGIN      = 4,
  parameter int MIN_HITS    = 2,
  parameter int LATCH_DELAY = 4,
  parameter int COUNT_W     = 8
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               game_on,
  input  logic [10:0]        pixelX,
  input  logic [10:0]        pixelY,
  input  logic               wallDrawingRequest,
  input  logic signed [10:0] enemyTopLeftX,
  input  logic signed [10:0] enemyTopLeftY,
  output logic               collision,
  output logic [3:0]         HitEdgeCode
);

  typedef enum logic [2:0] {
    IDLE_ST     = 3'd0,
    DELAY_ST    = 3'd1,
    SCAN_ST     = 3'd2,
    RESOLVE_ST  = 3'd3,
    REPORTED_ST = 3'd4
  } state_t;

  localparam logic signed [11:0] W_S    = 12'(OBJECT_W);
  localparam logic signed [11:0] H_S    = 12'(OBJECT_H);
  localparam logic signed [11:0] M_S    = 12'(MARGIN);
  localparam logic signed [11:0] ZERO_S = 12'sd0;

  localparam logic [COUNT_W-1:0] CNT_ZERO = COUNT_W'(0);
  localparam logic [COUNT_W-1:0] CNT_ONE  = COUNT_W'(1);
  localparam logic [COUNT_W-1:0] CNT_MAX  = {COUNT_W{1'b1}};
  localparam logic [COUNT_W-1:0] CNT_MIN  = COUNT_W'(MIN_HITS);

  localparam logic [7:0] DLY_LAST = 8'(LATCH_DELAY - 1);

  localparam logic [3:0] CODE_NONE   = 4'b0000;
  localparam logic [3:0] CODE_LEFT   = 4'b1000;
  localparam logic [3:0] CODE_TOP    = 4'b0100;
  localparam logic [3:0] CODE_RIGHT  = 4'b0010;
  localparam logic [3:0] CODE_BOTTOM = 4'b0001;

  // Saturating increment: the counter sticks at its maximum instead of wrapping.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] cnt,
                                                 input logic               en);
    return (en && (cnt != CNT_MAX)) ? (cnt + CNT_ONE) : cnt;
  endfunction

  logic [10:0]        px_r;
  logic [10:0]        py_r;
  logic               wall_r;
  logic signed [10:0] lat_x_r;
  logic signed [10:0] lat_y_r;
  logic [7:0]         dly_cnt_r;
  logic [COUNT_W-1:0] cnt_top_r;
  logic [COUNT_W-1:0] cnt_bottom_r;
  logic [COUNT_W-1:0] cnt_left_r;
  logic [COUNT_W-1:0] cnt_right_r;
  state_t             state_r;
  logic               collision_r;
  logic [3:0]         hit_code_r;

  logic signed [11:0] off_x_s;
  logic signed [11:0] off_y_s;
  logic               x_mid_s;
  logic               y_mid_s;
  logic               in_top_s;
  logic               in_bottom_s;
  logic               in_left_s;
  logic               in_right_s;
  logic [COUNT_W-1:0] best1_cnt_s;
  logic [3:0]         best1_code_s;
  logic [COUNT_W-1:0] best2_cnt_s;
  logic [3:0]         best2_code_s;
  logic [COUNT_W-1:0] best_cnt_s;
  logic [3:0]         best_code_s;
  logic               report_s;

  assign collision   = collision_r;
  assign HitEdgeCode = hit_code_r;

  // One-stage input pipeline; all classification works on these copies.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      px_r   <= 11'd0;
      py_r   <= 11'd0;
      wall_r <= 1'b0;
    end else begin
      px_r   <= pixelX;
      py_r   <= pixelY;
      wall_r <= wallDrawingRequest;
    end
  end

  // Box-relative offsets; zero-extend the raster, sign-extend the position.
  assign off_x_s = $signed({1'b0, px_r}) - $signed({lat_x_r[10], lat_x_r});
  assign off_y_s = $signed({1'b0, py_r}) - $signed({lat_y_r[10], lat_y_r});

  // Strip classification; the four corner squares belong to no strip.
  always_comb begin
    x_mid_s     = (off_x_s >= M_S) && (off_x_s < (W_S - M_S));
    y_mid_s     = (off_y_s >= M_S) && (off_y_s < (H_S - M_S));
    in_top_s    = (off_y_s >= ZERO_S) && (off_y_s < M_S) && x_mid_s;
    in_bottom_s = (off_y_s >= (H_S - M_S)) && (off_y_s < H_S) && x_mid_s;
    in_left_s   = (off_x_s >= ZERO_S) && (off_x_s < M_S) && y_mid_s;
    in_right_s  = (off_x_s >= (W_S - M_S)) && (off_x_s < W_S) && y_mid_s;
  end

  // Maximum search; strict '>' keeps the earlier strip on ties, giving
  // priority LEFT > RIGHT > TOP > BOTTOM.
  always_comb begin
    best1_cnt_s  = (cnt_right_r > cnt_left_r) ? cnt_right_r : cnt_left_r;
    best1_code_s = (cnt_right_r > cnt_left_r) ? CODE_RIGHT  : CODE_LEFT;
    best2_cnt_s  = (cnt_top_r > best1_cnt_s)  ? cnt_top_r   : best1_cnt_s;
    best2_code_s = (cnt_top_r > best1_cnt_s)  ? CODE_TOP    : best1_code_s;
    best_cnt_s   = (cnt_bottom_r > best2_cnt_s) ? cnt_bottom_r : best2_cnt_s;
    best_code_s  = (cnt_bottom_r > best2_cnt_s) ? CODE_BOTTOM  : best2_code_s;
    report_s     = (best_cnt_s >= CNT_MIN);
  end

  // Frame FSM with strip counters and registered outputs. The result is
  // registered on the SCAN->RESOLVE transition so the pulse is visible for
  // exactly the RESOLVE cycle. The pixel that ends the scan lies below the
  // box, so the counters are already final when they are compared.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r      <= IDLE_ST;
      collision_r  <= 1'b0;
      hit_code_r   <= CODE_NONE;
      cnt_top_r    <= CNT_ZERO;
      cnt_bottom_r <= CNT_ZERO;
      cnt_left_r   <= CNT_ZERO;
      cnt_right_r  <= CNT_ZERO;
      lat_x_r      <= 11'sd0;
      lat_y_r      <= 11'sd0;
      dly_cnt_r    <= 8'd0;
    end else if (!game_on) begin
      state_r      <= IDLE_ST;
      collision_r  <= 1'b0;
      hit_code_r   <= CODE_NONE;
      cnt_top_r    <= CNT_ZERO;
      cnt_bottom_r <= CNT_ZERO;
      cnt_left_r   <= CNT_ZERO;
      cnt_right_r  <= CNT_ZERO;
      dly_cnt_r    <= 8'd0;
    end else begin
      case (state_r)
        IDLE_ST: begin
          collision_r  <= 1'b0;
          hit_code_r   <= CODE_NONE;
          cnt_top_r    <= CNT_ZERO;
          cnt_bottom_r <= CNT_ZERO;
          cnt_left_r   <= CNT_ZERO;
          cnt_right_r  <= CNT_ZERO;
          dly_cnt_r    <= 8'd0;
          if (startOfFrame) begin
            state_r <= DELAY_ST;
          end else begin
            state_r <= IDLE_ST;
          end
        end
        DELAY_ST: begin
          collision_r <= 1'b0;
          // Give the enemy's own position update time to settle first.
          if (dly_cnt_r == DLY_LAST) begin
            lat_x_r      <= enemyTopLeftX;
            lat_y_r      <= enemyTopLeftY;
            cnt_top_r    <= CNT_ZERO;
            cnt_bottom_r <= CNT_ZERO;
            cnt_left_r   <= CNT_ZERO;
            cnt_right_r  <= CNT_ZERO;
            dly_cnt_r    <= 8'd0;
            state_r      <= SCAN_ST;
          end else begin
            dly_cnt_r <= dly_cnt_r + 8'd1;
            state_r   <= DELAY_ST;
          end
        end
        SCAN_ST: begin
          if (startOfFrame) begin
            // Box never finished (bottom-clipped): drop this frame silently.
            collision_r  <= 1'b0;
            cnt_top_r    <= CNT_ZERO;
            cnt_bottom_r <= CNT_ZERO;
            cnt_left_r   <= CNT_ZERO;
            cnt_right_r  <= CNT_ZERO;
            dly_cnt_r    <= 8'd0;
            state_r      <= DELAY_ST;
          end else if (off_y_s >= H_S) begin
            collision_r <= report_s;
            hit_code_r  <= report_s ? best_code_s : CODE_NONE;
            state_r     <= RESOLVE_ST;
          end else begin
            collision_r  <= 1'b0;
            cnt_top_r    <= sat_inc(cnt_top_r,    wall_r && in_top_s);
            cnt_bottom_r <= sat_inc(cnt_bottom_r, wall_r && in_bottom_s);
            cnt_left_r   <= sat_inc(cnt_left_r,   wall_r && in_left_s);
            cnt_right_r  <= sat_inc(cnt_right_r,  wall_r && in_right_s);
            state_r      <= SCAN_ST;
          end
        end
        RESOLVE_ST: begin
          collision_r <= 1'b0;
          state_r     <= REPORTED_ST;
        end
        REPORTED_ST: begin
          collision_r <= 1'b0;
          if (startOfFrame) begin
            hit_code_r <= CODE_NONE;
            dly_cnt_r  <= 8'd0;
            state_r    <= DELAY_ST;
          end else begin
            state_r <= REPORTED_ST;
          end
        end
        default: begin
          state_r      <= IDLE_ST;
          collision_r  <= 1'b0;
          hit_code_r   <= CODE_NONE;
          cnt_top_r    <= CNT_ZERO;
          cnt_bottom_r <= CNT_ZERO;
          cnt_left_r   <= CNT_ZERO;
          cnt_right_r  <= CNT_ZERO;
          dly_cnt_r    <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enemy_hit_detector.sv
// -----------------------------------------------------------------------------
// tb_enemy_hit_detector
//
// Self-checking bench for enemy_hit_detector. Each frame drives a startOfFrame
// pulse, waits out the latch delay and rasters a window around the enemy box
// with a chosen wall pattern. The expected edge code for every frame that
// should report is pushed to a scoreboard queue, and a negedge monitor pops
// it whenever collision pulses. Frame-end checks cover the pulse count and
// the held code.
// -----------------------------------------------------------------------------
module tb_enemy_hit_detector;

  logic               clk;
  logic               resetN;
  logic               startOfFrame;
  logic               game_on;
  logic [10:0]        pixelX;
  logic [10:0]        pixelY;
  logic               wallDrawingRequest;
  logic signed [10:0] enemyTopLeftX;
  logic signed [10:0] enemyTopLeftY;
  logic               collision;
  logic [3:0]         HitEdgeCode;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         frame_pulses = 0;
  logic [3:0] sb_q[$];
  logic [3:0] sb_exp;

  localparam int P_RIGHT  = 0;
  localparam int P_TOP2   = 1;
  localparam int P_ONE    = 2;
  localparam int P_TWO    = 3;
  localparam int P_LR     = 4;
  localparam int P_CORNER = 5;
  localparam int P_COL31  = 6;
  localparam int P_BOT    = 7;
  localparam int P_TB     = 8;
  localparam int P_RT     = 9;

  localparam int M_NORMAL    = 0;
  localparam int M_MOVE_DLY  = 1;
  localparam int M_MOVE_SCAN = 2;
  localparam int M_ABORT_GON = 3;
  localparam int M_ABORT_RST = 4;

  enemy_hit_detector dut (
    .clk                (clk),
    .resetN             (resetN),
    .startOfFrame       (startOfFrame),
    .game_on            (game_on),
    .pixelX             (pixelX),
    .pixelY             (pixelY),
    .wallDrawingRequest (wallDrawingRequest),
    .enemyTopLeftX      (enemyTopLeftX),
    .enemyTopLeftY      (enemyTopLeftY),
    .collision          (collision),
    .HitEdgeCode        (HitEdgeCode)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #600000;
    $display("FAIL timeout: simulation exceeded its time limit (checks=%0d)", n_checks);
    $fatal(1, "time limit expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wall patterns, in offsets relative to the box top-left corner.
  function automatic logic is_wall(input int pat, input int ox, input int oy);
    logic r;
    r = 1'b0;
    case (pat)
      P_RIGHT:  r = (ox >= 28 && ox <= 31 && oy >= 0 && oy <= 31);
      P_TOP2:   r = (oy >= 0 && oy <= 1 && ox >= 4 && ox <= 27);
      P_ONE:    r = (ox == 4 && oy == 0);
      P_TWO:    r = ((ox == 4 || ox == 5) && oy == 0);
      P_LR:     r = (((ox >= 0 && ox <= 3) || (ox >= 28 && ox <= 31)) && oy >= 4 && oy <= 27);
      P_CORNER: r = (ox >= 0 && ox <= 3 && oy >= 0 && oy <= 3);
      P_COL31:  r = (ox == 31 && oy >= 4 && oy <= 27);
      P_BOT:    r = (oy >= 28 && oy <= 31 && ox >= 4 && ox <= 27);
      P_TB:     r = (((oy >= 0 && oy <= 1) || (oy >= 30 && oy <= 31)) && ox >= 4 && ox <= 27);
      P_RT:     r = ((ox >= 28 && ox <= 29 && oy >= 4 && oy <= 27) ||
                     (oy >= 0 && oy <= 1 && ox >= 4 && ox <= 27));
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

  // Scoreboard monitor: every pulse must match the oldest expected code.
  always @(negedge clk) begin
    if (collision === 1'b1) begin
      frame_pulses++;
      if (sb_q.size() == 0) begin
        check_eq("unexpected_pulse", {31'd0, collision}, 32'd0);
      end else begin
        sb_exp = sb_q.pop_front();
        check_eq("pulse_code", {28'd0, HitEdgeCode}, {28'd0, sb_exp});
      end
    end
  end

  task automatic run_frame(input int bx, input int by, input int pat,
                           input logic [3:0] exp_code, input int mode);
    int y0;
    frame_pulses = 0;
    if (exp_code != 4'b0000) sb_q.push_back(exp_code);
    enemyTopLeftX = (mode == M_MOVE_DLY) ? 11'(bx - 1) : 11'(bx);
    enemyTopLeftY = 11'(by);
    pixelX = 11'd0;
    pixelY = 11'd0;
    wallDrawingRequest = 1'b0;
    tick();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    @(negedge clk);
    check_eq("sof_code_clear", {28'd0, HitEdgeCode}, 32'd0);
    check_eq("sof_coll_low", {31'd0, collision}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      // Position settles two cycles after the frame start, before the latch.
      if (mode == M_MOVE_DLY && i == 0) enemyTopLeftX = 11'(bx);
    end
    if (mode == M_MOVE_SCAN) enemyTopLeftX = 11'(bx + 40);
    y0 = (by - 4 < 0) ? 0 : by - 4;
    for (int y = y0; y <= by + 33; y++) begin
      for (int x = bx - 4; x <= bx + 35; x++) begin
        tick();
        pixelX = 11'(x);
        pixelY = 11'(y);
        wallDrawingRequest = is_wall(pat, x - bx, y - by);
        if (x == bx && y == by + 16) begin
          if (mode == M_ABORT_GON) begin
            game_on = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check_eq("gon_abort_coll", {31'd0, collision}, 32'd0);
            check_eq("gon_abort_code", {28'd0, HitEdgeCode}, 32'd0);
            game_on = 1'b1;
          end else if (mode == M_ABORT_RST) begin
            resetN = 1'b0;
            #1;
            check_eq("rst_abort_coll", {31'd0, collision}, 32'd0);
            check_eq("rst_abort_code", {28'd0, HitEdgeCode}, 32'd0);
            @(negedge clk);
            resetN = 1'b1;
          end
        end
      end
    end
    tick();
    wallDrawingRequest = 1'b0;
    tick();
    tick();
    tick();
    @(negedge clk);
    check_eq("frame_pulses", frame_pulses, (exp_code != 4'b0000) ? 32'd1 : 32'd0);
    check_eq("held_code", {28'd0, HitEdgeCode}, {28'd0, exp_code});
  endtask

  // Main stimulus sequence.
  initial begin
    resetN             = 1'b0;
    startOfFrame       = 1'b0;
    game_on            = 1'b0;
    pixelX             = 11'd0;
    pixelY             = 11'd0;
    wallDrawingRequest = 1'b0;
    enemyTopLeftX      = 11'sd0;
    enemyTopLeftY      = 11'sd0;
    #22;
    check_eq("reset_coll", {31'd0, collision}, 32'd0);
    check_eq("reset_code", {28'd0, HitEdgeCode}, 32'd0);
    @(negedge clk);
    resetN  = 1'b1;
    game_on = 1'b1;

    run_frame(100, 200, P_RIGHT,  4'b0010, M_NORMAL);
    run_frame(100, 200, P_TOP2,   4'b0100, M_NORMAL);
    run_frame(100, 200, P_ONE,    4'b0000, M_NORMAL);
    run_frame(100, 200, P_TWO,    4'b0100, M_NORMAL);
    run_frame(100, 200, P_LR,     4'b1000, M_NORMAL);
    run_frame(100, 200, P_CORNER, 4'b0000, M_NORMAL);
    run_frame(100, 200, P_TB,     4'b0100, M_NORMAL);
    run_frame(100, 200, P_RT,     4'b0010, M_NORMAL);
    run_frame(300, -8,  P_BOT,    4'b0001, M_NORMAL);

    // game_on drop while a code is held clears it on the next cycle.
    tick();
    game_on = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("gon_drop_code", {28'd0, HitEdgeCode}, 32'd0);
    game_on = 1'b1;

    run_frame(101, 200, P_COL31,  4'b0010, M_MOVE_DLY);
    run_frame(100, 200, P_RIGHT,  4'b0010, M_MOVE_SCAN);

    // Asynchronous reset while a code is held clears it immediately.
    tick();
    resetN = 1'b0;
    #1;
    check_eq("rst_drop_code", {28'd0, HitEdgeCode}, 32'd0);
    @(negedge clk);
    resetN = 1'b1;

    run_frame(100, 200, P_RIGHT,  4'b0000, M_ABORT_GON);
    run_frame(100, 200, P_RIGHT,  4'b0010, M_NORMAL);
    run_frame(100, 200, P_RIGHT,  4'b0000, M_ABORT_RST);
    run_frame(100, 200, P_LR,     4'b1000, M_NORMAL);

    check_eq("scoreboard_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
